// File: rtl/mem_master_if.sv
// mem_master_if: bundle of command, write-beat, read-stream and RAM port signals for mem_master.
// master: the mem_master side (drives cmd_ready, wr_ready, rd_*, mem_ad/we/wd, busy).
// slave: the environment side (drives cmd_*, wr_valid/data, rd_ready, mem_rd).
interface mem_master_if #(
  parameter int MEM_SIZE  = 8,
  parameter int DATA_SIZE = 8,
  parameter int LEN_SIZE  = 4
);
  logic                 cmd_valid, cmd_ready, cmd_we;
  logic [MEM_SIZE-1:0]  cmd_addr;
  logic [LEN_SIZE-1:0]  cmd_len;
  logic                 wr_valid, wr_ready;
  logic [DATA_SIZE-1:0] wr_data;
  logic                 rd_valid, rd_ready, rd_last;
  logic [DATA_SIZE-1:0] rd_data;
  logic [MEM_SIZE-1:0]  mem_ad;
  logic                 mem_we;
  logic [DATA_SIZE-1:0] mem_wd, mem_rd;
  logic                 busy;
  modport master(
    input  cmd_valid, cmd_we, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, mem_rd,
    output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, mem_ad, mem_we, mem_wd, busy
  );
  modport slave(
    output cmd_valid, cmd_we, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, mem_rd,
    input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, mem_ad, mem_we, mem_wd, busy
  );
endinterface

// File: rtl/mem_master.sv
// mem_master: burst read/write initiator for a single-port RAM with a 2-entry read skid buffer.
// Ports: clk, rst (async active-high), bus (mem_master_if.master: cmd, write beats, read stream, RAM port, busy).
module mem_master #(
  parameter int MEM_SIZE  = 8,
  parameter int DATA_SIZE = 8,
  parameter int LEN_SIZE  = 4
) (
  input logic          clk,
  input logic          rst,
  mem_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
  state_t               state;
  logic [MEM_SIZE-1:0]  addr;
  logic [LEN_SIZE-1:0]  remain;
  logic                 pend, pend_last;
  logic [1:0]           cnt;
  logic [DATA_SIZE-1:0] buf_d [2];
  logic [1:0]           buf_l;
  logic                 pop, issue, wi;
  always_comb begin
    pop   = (cnt != 2'd0) && bus.rd_ready;
    // occupancy after this edge must leave room for the beat being issued now
    issue = (state == READ) && (({1'b0, cnt} + {2'b0, pend} - {2'b0, pop}) < 3'd2);
    // slot the returning word lands in once the head has (maybe) shifted out
    wi    = cnt[0] ^ pop;
  end
  assign bus.cmd_ready = state == IDLE;
  assign bus.busy      = state != IDLE;
  assign bus.wr_ready  = state == WRITE;
  assign bus.mem_we    = (state == WRITE) && bus.wr_valid;
  assign bus.mem_wd    = bus.wr_data;
  assign bus.mem_ad    = addr;
  assign bus.rd_valid  = cnt != 2'd0;
  assign bus.rd_data   = buf_d[0];
  assign bus.rd_last   = bus.rd_valid && buf_l[0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remain    <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      cnt       <= '0;
      buf_d     <= '{default: '0};
      buf_l     <= '0;
    end else begin
      pend <= issue;
      if (issue) pend_last <= remain == '0;
      cnt <= cnt + {1'b0, pend} - {1'b0, pop};
      if (pop) begin
        buf_d[0] <= buf_d[1];
        buf_l[0] <= buf_l[1];
      end
      if (pend) begin
        buf_d[wi] <= bus.mem_rd;
        buf_l[wi] <= pend_last;
      end
      case (state)
        IDLE: if (bus.cmd_valid) begin
          addr   <= bus.cmd_addr;
          remain <= bus.cmd_len;
          state  <= bus.cmd_we ? WRITE : READ;
        end
        WRITE: if (bus.wr_valid) begin
          addr <= addr + 1'b1;
          if (remain == '0) state <= IDLE;
          else remain <= remain - 1'b1;
        end
        READ: if (issue) begin
          addr <= addr + 1'b1;
          if (remain == '0) state <= DRAIN;
          else remain <= remain - 1'b1;
        end
        // leave as the last buffered beat pops so cmd_ready rises right after it
        DRAIN: if (!pend && cnt == {1'b0, pop}) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: scoreboard bench for mem_master with a RAM model and a reference memory image.
module tb_mem_master;
  logic clk, rst;
  int checks, failures, rd_mode;
  logic [7:0] ram [256];
  logic [7:0] seed [256];
  logic [7:0] ref_mem [256];
  logic init_done;
  logic [8:0] rq [$];
  logic [15:0] wq [$];

  mem_master_if bus ();
  mem_master dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) ram[i] <= seed[i];
      init_done <= 1'b1;
    end else if (bus.mem_we) ram[bus.mem_ad] <= bus.mem_wd;
    bus.mem_rd <= ram[bus.mem_ad];
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic flag(input string n);
    checks++;
    failures++;
    $display("FAIL %s", n);
  endtask

  task automatic reset_checks();
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_wr_ready", bus.wr_ready, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_last", bus.rd_last, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_ad", bus.mem_ad, 0);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!(bus.cmd_ready && rq.size() == 0 && wq.size() == 0) && k < 500) begin
      @(posedge clk); #1; k++;
    end
    chk("idle_timeout", k >= 500, 0);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [3:0] len, input logic [7:0] d0,
                          input bit rnd, input bit gaps, input bit timed);
    int i = 0, k = 0;
    logic [7:0] d;
    bus.cmd_valid = 1; bus.cmd_we = 1; bus.cmd_addr = a; bus.cmd_len = len;
    @(posedge clk); #1;
    bus.cmd_valid = 0;
    while (i <= int'(len) && k < 200) begin
      bus.wr_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      d = rnd ? 8'($urandom) : d0 + 8'(i);
      bus.wr_data = d;
      if (bus.wr_valid) begin
        wq.push_back({a + 8'(i), d});
        ref_mem[a + 8'(i)] = d;
        i++;
      end
      @(negedge clk);
      if (bus.wr_valid) chk("wr_ready", bus.wr_ready, 1);
      if (timed) chk("wr_busy", bus.busy, 1);
      @(posedge clk); #1;
      k++;
    end
    bus.wr_valid = 0;
    if (timed) chk("wr_cmd_ready_back", bus.cmd_ready, 1);
    wait_idle();
  endtask

  task automatic do_read(input logic [7:0] a, input logic [3:0] len, input int mode, input bit timed);
    int first = 0, idle = 0;
    rd_mode = mode;
    for (int i = 0; i <= int'(len); i++) rq.push_back({i == int'(len), ref_mem[a + 8'(i)]});
    bus.cmd_valid = 1; bus.cmd_we = 0; bus.cmd_addr = a; bus.cmd_len = len;
    @(posedge clk); #1;
    bus.cmd_valid = 0;
    if (timed) begin
      for (int k = 1; k <= int'(len) + 6; k++) begin
        @(negedge clk);
        if (bus.rd_valid && first == 0) first = k;
        if (bus.cmd_ready && idle == 0) idle = k;
      end
      chk("rd_first_latency", first, 3);
      chk("rd_idle_cycle", idle, int'(len) + 4);
    end
    wait_idle();
  endtask

  initial begin : rd_drv
    int ph;
    ph = 0;
    forever begin
      @(posedge clk); #1;
      ph++;
      bus.rd_ready = rd_mode == 0 ? 1'b1 : rd_mode == 1 ? 1'($urandom_range(0, 1)) :
                     rd_mode == 2 ? (ph % 3 == 0) : 1'b0;
    end
  end

  initial begin : mon
    logic [8:0] hold, e9;
    logic [15:0] e16;
    logic stall;
    stall = 0;
    hold = '0;
    forever begin
      @(negedge clk);
      if (rst) stall = 0;
      else begin
        if (stall) chk("rd_hold", {bus.rd_valid, bus.rd_last, bus.rd_data}, {1'b1, hold});
        if (bus.rd_valid && bus.rd_ready) begin
          if (rq.size() == 0) flag("rd_unexpected_beat");
          else begin
            e9 = rq.pop_front();
            chk("rd_beat", {bus.rd_last, bus.rd_data}, e9);
          end
        end
        if (bus.mem_we) begin
          if (wq.size() == 0) flag("mem_unexpected_write");
          else begin
            e16 = wq.pop_front();
            chk("mem_write", {bus.mem_ad, bus.mem_wd}, e16);
          end
        end
        stall = bus.rd_valid && !bus.rd_ready;
        hold = {bus.rd_last, bus.rd_data};
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    checks = 0; failures = 0; rd_mode = 0; init_done = 0;
    rst = 1;
    bus.cmd_valid = 0; bus.cmd_we = 0; bus.cmd_addr = 0; bus.cmd_len = 0;
    bus.wr_valid = 0; bus.wr_data = 0; bus.rd_ready = 0;
    for (int i = 0; i < 256; i++) begin
      seed[i] = 8'($urandom);
      ref_mem[i] = seed[i];
    end
    @(negedge clk);
    reset_checks();
    @(posedge clk); #1;
    rst = 0;
    do_write(8'h10, 4'd3, 8'hA0, 0, 0, 1);
    do_read(8'h10, 4'd3, 0, 1);
    do_read(8'h10, 4'd3, 2, 0);
    do_write(8'hFE, 4'd3, 8'h50, 0, 0, 1);
    do_read(8'hFE, 4'd3, 0, 1);
    do_write(8'h40, 4'd5, 8'h00, 1, 1, 0);
    do_read(8'h40, 4'd5, 1, 0);
    do_read(8'h77, 4'd0, 0, 1);
    rd_mode = 3;
    bus.cmd_valid = 1; bus.cmd_we = 0; bus.cmd_addr = 8'h10; bus.cmd_len = 4'd7;
    @(posedge clk); #1;
    bus.cmd_valid = 0;
    repeat (5) begin @(posedge clk); #1; end
    chk("pre_rst_rd_valid", bus.rd_valid, 1);
    rst = 1;
    #1;
    reset_checks();
    @(negedge clk);
    @(posedge clk); #1;
    rst = 0;
    rd_mode = 0;
    do_read(8'h10, 4'd3, 0, 1);
    for (int t = 0; t < 12; t++) begin
      logic [7:0] a;
      logic [3:0] l;
      a = 8'($urandom);
      l = 4'($urandom);
      do_write(a, l, 8'h00, 1, 1'($urandom_range(0, 1)), 0);
      do_read(a, l, $urandom_range(0, 2), 0);
      if ($urandom_range(0, 1) == 1) do_read(8'($urandom), 4'($urandom), $urandom_range(0, 2), 0);
    end
    chk("rq_empty", rq.size(), 0);
    chk("wq_empty", wq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_master.md
# mem_master

Command-driven initiator for the single-port `mem` RAM. It accepts burst read/write commands on a valid/ready interface and drives the RAM address, write-enable and write-data port. It absorbs the RAM's one-cycle registered read latency with a 2-entry skid buffer, so read data can be returned on a back-pressurable stream. It sits between the datapath/controller and `mem`, and is the only agent driving the RAM port.

## Interface
- `MEM_SIZE`, 8, RAM address width; RAM depth is 2**MEM_SIZE.
- `DATA_SIZE`, 8, data word width.
- `LEN_SIZE`, 4, burst length field width; beats per command = `cmd_len`+1.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command (high only in IDLE).
- `cmd_we` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr` in MEM_SIZE: burst start address.
- `cmd_len` in LEN_SIZE: beats minus one.
- `wr_valid` in 1: write beat present.
- `wr_ready` out 1: write beat accepted.
- `wr_data` in DATA_SIZE: write beat data.
- `rd_valid` out 1: read beat present.
- `rd_ready` in 1: consumer accepts the read beat.
- `rd_data` out DATA_SIZE: read beat data.
- `rd_last` out 1: marks the final beat of a read burst.
- `mem_ad` out MEM_SIZE: to RAM `ad`.
- `mem_we` out 1: to RAM `we`.
- `mem_wd` out DATA_SIZE: to RAM `wd`.
- `mem_rd` in DATA_SIZE: from RAM `rd`; valid in the cycle after the address is presented.
- `busy` out 1: high whenever state is not IDLE.

## Operation
- **States:** IDLE, WRITE, READ, DRAIN.
- **Registers:** `addr` (MEM_SIZE), `remain` (LEN_SIZE), `pend` (1 = read issued last cycle), buffer `cnt` (0..2) with 2 data entries plus a last flag each.
- **Command accept:** IDLE and `cmd_valid` → latch `cmd_addr` into `addr` and `cmd_len` into `remain`. Go to WRITE if `cmd_we`=1, else READ. Commands are never accepted outside IDLE.
- **Port mapping:** `mem_ad` = `addr` at all times.
- **WRITE:**
  - `wr_ready`=1.
  - `mem_we` = `wr_valid`; `mem_wd` = `wr_data`.
  - Each accepted beat: `addr`+1 mod 2**MEM_SIZE.
  - On the beat with `remain`=0 → IDLE; otherwise `remain`-1.
  - `mem_we`=0 and `wr_ready`=0 in every other state.
- **READ issue:**
  - Issue rule: issue when `cnt` + `pend` − pop < 2, where pop = `rd_valid` & `rd_ready`.
  - Issuing a beat: `addr`+1 (wraps), `pend` set next cycle, beat tagged last if `remain`=0.
  - After the last issue → DRAIN; otherwise `remain`-1.
- **Capture:** when `pend`=1, `mem_rd` and its last tag are pushed into the buffer at that clock edge.
- **Buffer:** FIFO order. Simultaneous push and pop is allowed and keeps `cnt` unchanged. Overflow is impossible by the issue rule.
- **Read output:** `rd_valid` = (`cnt`>0); `rd_data`/`rd_last` come from the head entry.
- **DRAIN:** no issue. Go to IDLE when `cnt`=0 and `pend`=0.
- **Address wrap:** `addr` wraps from 2**MEM_SIZE−1 to 0 silently.
- **Reset (asserted at any time, including mid-burst):**
  - State → IDLE; `addr`, `remain`, `pend`, `cnt` → 0.
  - In-flight read data is discarded and partial bursts are abandoned.
  - Output values during/after reset: `cmd_ready`=1, `busy`=0, `wr_ready`=0, `rd_valid`=0, `rd_last`=0, `mem_we`=0, `mem_ad`=0.
  - `rd_data`/`mem_wd` are don't-care while their qualifiers are low.

## Timing
- **Command accept:** command accepted at edge E; first WRITE or READ cycle is E+1.
- **Write:** beat written into the RAM at the same edge it is accepted; zero extra latency. No bubbles occur while `wr_valid`=1.
- **Read latency:** address issued in cycle t; `mem_rd` valid in t+1; pushed at the end of t+1; `rd_valid` in t+2. The first `rd_valid` appears 3 cycles after the command-accept edge.
- **Read throughput:** with `rd_ready` held at 1, one beat per cycle sustained. Burst of N beats: last `rd_valid` at accept+N+2, IDLE on the following cycle.
- **Back-pressure:** `rd_valid`/`rd_data`/`rd_last` are held stable while `rd_ready`=0. Issue stalls once `cnt`+`pend` reaches 2; it resumes in the cycle a pop occurs.
- **Next command:** `cmd_ready` rises the cycle after the final write beat, or the cycle after the final read pop.

## Test plan
- **Write burst:** write cmd addr 0x10, len 3, data 0xA0..0xA3 with `wr_valid` steady → `mem_we` high 4 consecutive cycles at `mem_ad` 0x10..0x13; `cmd_ready` back 1 cycle later.
- **Read-back, no back-pressure:** read cmd 0x10, len 3, `rd_ready`=1 → `rd_data` 0xA0..0xA3 on 4 consecutive cycles starting 3 cycles after accept; `rd_last` only on 0xA3.
- **Read back-pressure:** same read with `rd_ready` toggling 1,0,0,1,... → no lost or duplicated beats; data held stable while stalled; `cnt` never exceeds 2.
- **Wrap-around:** write then read at 0xFE, len 3 (MEM_SIZE=8) → addresses 0xFE,0xFF,0x00,0x01; data returned in order.
- **Write gaps and len 0:** write burst with `wr_valid` gaps → `mem_we` only on valid cycles and `addr` advances only then. Single-beat read (len 0) → one beat, with `rd_last`=1.
- **Reset mid-read:** assert `rst` mid-read with 2 beats buffered → `rd_valid`=0, `busy`=0 and `cmd_ready`=1 immediately. A new read after release returns correct data with no stale beats.
